// File: rtl/mar_pkg.sv
// Shared types and helpers for the MAR access controller.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   state_t      access FSM state encoding
//   ZEXT_MAX_W   widest address the zero-extension helper handles
//   zext_vect()  keep only the low vect_w bits of a (pre-widened) trap vector
package mar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int ZEXT_MAX_W = 64;

    // Callers widen the vector to ZEXT_MAX_W and truncate the result to their
    // own address width; the mask guarantees that nothing above the vector
    // field can leak into the address even if the caller widened a wider bus.
    function automatic logic [ZEXT_MAX_W-1:0] zext_vect(
        input logic [ZEXT_MAX_W-1:0] vect,
        input int unsigned           vect_w
    );
        logic [ZEXT_MAX_W-1:0] mask;
        mask = {ZEXT_MAX_W{1'b1}} >> (ZEXT_MAX_W - vect_w);
        return vect & mask;
    endfunction

endpackage

// File: rtl/mar_access_ctrl_if.sv
// Bundle of the control-side and memory-side signals of the MAR access controller.
// Latency: n/a (wiring only).
// Backpressure: mem_ready is the only stall source; it comes in through this bundle.
//
// master: control FSM / datapath / memory side (drives requests and mem_ready).
// slave : mar_access_ctrl (drives the MAR, memory strobes and status).
interface mar_access_ctrl_if #(
    parameter int ADDR_W    = 16,
    parameter int VECT_W    = 8,
    parameter int BURST_MAX = 4
);
    localparam int BL_W = $clog2(BURST_MAX + 1);

    logic [VECT_W-1:0] ir_vect;
    logic [ADDR_W-1:0] eab_out;
    logic              sel_mar;
    logic              ld_mar;
    logic              start;
    logic              wr;
    logic [BL_W-1:0]   burst_len;
    logic              mem_ready;

    logic [ADDR_W-1:0] mar_mux;
    logic [ADDR_W-1:0] mar_q;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_we;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output ir_vect, eab_out, sel_mar, ld_mar, start, wr, burst_len, mem_ready,
        input  mar_mux, mar_q, mem_addr, mem_en, mem_we, busy, done, err
    );

    modport slave (
        input  ir_vect, eab_out, sel_mar, ld_mar, start, wr, burst_len, mem_ready,
        output mar_mux, mar_q, mem_addr, mem_en, mem_we, busy, done, err
    );

endinterface

// File: rtl/mar_zext_mux.sv
// MAR input mux: zero-extended trap vector or effective-address bus.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_ir_vect  VECT_W  trap vector (IR low bits)
//   i_eab_out  ADDR_W  effective-address bus
//   i_sel_mar  1       1 = zero-extended trap vector, 0 = EAB
//   o_mar_mux  ADDR_W  selected address
module mar_zext_mux
    import mar_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int VECT_W = 8    // must not exceed ADDR_W
) (
    input  logic [VECT_W-1:0] i_ir_vect,
    input  logic [ADDR_W-1:0] i_eab_out,
    input  logic              i_sel_mar,
    output logic [ADDR_W-1:0] o_mar_mux
);

    logic [ADDR_W-1:0] w_vect_addr;

    assign w_vect_addr = ADDR_W'(zext_vect(ZEXT_MAX_W'(i_ir_vect), VECT_W));
    assign o_mar_mux   = i_sel_mar ? w_vect_addr : i_eab_out;

endmodule

// File: rtl/mar_access_ctrl.sv
// MAR register plus single/burst memory-access FSM with auto-increment and wait timeout.
// Latency: start -> first mem_en cycle is 1 edge; one word per mem_ready; done 1 edge after last word.
// Backpressure: mem_ready low stalls the current word; WAIT_MAX+1 stalled cycles abort with err.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mar_access_ctrl_if.slave: request inputs (ir_vect, eab_out, sel_mar, ld_mar,
//          start, wr, burst_len, mem_ready) and outputs (mar_mux, mar_q, mem_addr,
//          mem_en, mem_we, busy, done, err)
module mar_access_ctrl
    import mar_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int VECT_W    = 8,
    parameter int BURST_MAX = 4,
    parameter int WAIT_MAX  = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mar_access_ctrl_if.slave     bus
);

    localparam int BL_W = $clog2(BURST_MAX + 1);
    localparam int WT_W = $clog2(WAIT_MAX + 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_mar;
    logic [BL_W-1:0]   r_len;
    logic [BL_W-1:0]   r_count;
    logic [WT_W-1:0]   r_timer;
    logic              r_mem_en;
    logic              r_mem_we;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [ADDR_W-1:0] w_mar_mux;
    logic [BL_W-1:0]   w_len;

    mar_zext_mux #(
        .ADDR_W (ADDR_W),
        .VECT_W (VECT_W)
    ) u_zext_mux (
        .i_ir_vect (bus.ir_vect),
        .i_eab_out (bus.eab_out),
        .i_sel_mar (bus.sel_mar),
        .o_mar_mux (w_mar_mux)
    );

    // A zero length still moves one word; oversize requests are clipped.
    always_comb begin
        w_len = bus.burst_len;
        if (bus.burst_len == '0) begin
            w_len = BL_W'(1);
        end else if (bus.burst_len > BL_W'(BURST_MAX)) begin
            w_len = BL_W'(BURST_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mar    <= '0;
            r_len    <= '0;
            r_count  <= '0;
            r_timer  <= '0;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Load is written before the start check so a combined
                    // ld_mar+start launches at the freshly loaded address.
                    if (bus.ld_mar) begin
                        r_mar <= w_mar_mux;
                    end
                    if (bus.start) begin
                        r_len    <= w_len;
                        r_count  <= '0;
                        r_timer  <= '0;
                        r_err    <= 1'b0;
                        r_mem_en <= 1'b1;
                        r_mem_we <= bus.wr;
                        r_busy   <= 1'b1;
                        r_state  <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (bus.mem_ready) begin
                        r_count <= r_count + 1'b1;
                        r_mar   <= r_mar + 1'b1;   // wraps at the top of the address space
                        r_timer <= '0;
                        if ((r_count + 1'b1) == r_len) begin
                            r_mem_en <= 1'b0;
                            r_mem_we <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end else if (r_timer == WT_W'(WAIT_MAX)) begin
                        // MAR is left on the word that never completed.
                        r_err    <= 1'b1;
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mar_mux  = w_mar_mux;
    assign bus.mar_q    = r_mar;
    assign bus.mem_addr = r_mar;
    assign bus.mem_en   = r_mem_en;
    assign bus.mem_we   = r_mem_we;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_mar_access_ctrl.sv
module tb_mar_access_ctrl;

    localparam int ADDR_W    = 16;
    localparam int VECT_W    = 8;
    localparam int BURST_MAX = 4;
    localparam int WAIT_MAX  = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mar_access_ctrl_if #(.ADDR_W(ADDR_W), .VECT_W(VECT_W), .BURST_MAX(BURST_MAX)) bus ();

    mar_access_ctrl #(
        .ADDR_W    (ADDR_W),
        .VECT_W    (VECT_W),
        .BURST_MAX (BURST_MAX),
        .WAIT_MAX  (WAIT_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model (transaction-level bookkeeping) ----------------
    logic [15:0] m_mar;
    bit          m_act;     // a transfer is in flight
    bit          m_done;    // completion cycle being shown
    bit          m_err;
    bit          m_we;
    int          m_left;    // words still to move
    int          m_stalls;  // consecutive cycles without mem_ready

    function automatic logic [15:0] exp_mux();
        return bus.sel_mar ? {8'h00, bus.ir_vect} : bus.eab_out;
    endfunction

    function automatic void model_step();
        if (!rst_n) begin
            m_mar = 16'h0; m_act = 0; m_done = 0; m_err = 0; m_we = 0;
            m_left = 0; m_stalls = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_act) begin
            if (bus.mem_ready) begin
                m_mar = m_mar + 16'd1;
                m_left = m_left - 1;
                m_stalls = 0;
                if (m_left == 0) begin
                    m_act = 0;
                    m_done = 1;
                end
            end else begin
                m_stalls = m_stalls + 1;
                if (m_stalls > WAIT_MAX) begin
                    m_act = 0;
                    m_err = 1;
                end
            end
        end else begin
            if (bus.ld_mar) m_mar = exp_mux();
            if (bus.start) begin
                int n;
                n = int'(bus.burst_len);
                if (n == 0) n = 1;
                if (n > BURST_MAX) n = BURST_MAX;
                m_left = n;
                m_we = bus.wr;
                m_err = 0;
                m_stalls = 0;
                m_act = 1;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " mar_q"},    32'(bus.mar_q),    32'(m_mar));
        chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(m_mar));
        chk({tag, " mem_en"},   32'(bus.mem_en),   32'(m_act));
        chk({tag, " mem_we"},   32'(bus.mem_we),   32'(m_act & m_we));
        chk({tag, " busy"},     32'(bus.busy),     32'(m_act | m_done));
        chk({tag, " done"},     32'(bus.done),     32'(m_done));
        chk({tag, " err"},      32'(bus.err),      32'(m_err));
        chk({tag, " mar_mux"},  32'(bus.mar_mux),  32'(exp_mux()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic r, input logic ld, input logic sel, input logic [7:0] v,
                         input logic [15:0] e, input logic st, input logic w,
                         input logic [2:0] bl, input logic rdy);
        rst_n = r; bus.ld_mar = ld; bus.sel_mar = sel; bus.ir_vect = v; bus.eab_out = e;
        bus.start = st; bus.wr = w; bus.burst_len = bl; bus.mem_ready = rdy;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       nm;
        logic        r, ld, sel;
        logic [7:0]  v;
        logic [15:0] e;
        logic        st, w;
        logic [2:0]  bl;
        logic        rdy;
        logic [15:0] e_mar, e_mux;
        logic        e_en, e_we, e_busy, e_done, e_err;
    } vec_t;

    localparam int NVEC = 27;
    vec_t tbl [NVEC];

    function automatic vec_t mk(string nm, logic r, logic ld, logic sel, logic [7:0] v,
                                logic [15:0] e, logic st, logic w, logic [2:0] bl, logic rdy,
                                logic [15:0] emar, logic [15:0] emux,
                                logic en, logic we, logic bsy, logic dn, logic er);
        vec_t x;
        x.nm = nm; x.r = r; x.ld = ld; x.sel = sel; x.v = v; x.e = e; x.st = st; x.w = w;
        x.bl = bl; x.rdy = rdy; x.e_mar = emar; x.e_mux = emux; x.e_en = en; x.e_we = we;
        x.e_busy = bsy; x.e_done = dn; x.e_err = er;
        return x;
    endfunction

    initial begin
        //                 name          r ld sel vect   eab     st wr bl rdy  mar      mux      en we bsy dn er
        tbl[0]  = mk("reset1",        0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
        tbl[1]  = mk("reset2",        0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
        tbl[2]  = mk("trap_ld",       1, 1, 1, 8'h25, 16'h1234, 0, 0, 0, 0, 16'h0025, 16'h0025, 0, 0, 0, 0, 0);
        tbl[3]  = mk("eab_ld",        1, 1, 0, 8'h25, 16'h3000, 0, 0, 0, 0, 16'h3000, 16'h3000, 0, 0, 0, 0, 0);
        tbl[4]  = mk("rd_start",      1, 0, 0, 8'h00, 16'h3000, 1, 0, 3, 1, 16'h3000, 16'h3000, 1, 0, 1, 0, 0);
        tbl[5]  = mk("rd_w1",         1, 0, 0, 8'h00, 16'h3000, 0, 0, 0, 1, 16'h3001, 16'h3000, 1, 0, 1, 0, 0);
        tbl[6]  = mk("rd_w2",         1, 0, 0, 8'h00, 16'h3000, 0, 0, 0, 1, 16'h3002, 16'h3000, 1, 0, 1, 0, 0);
        tbl[7]  = mk("rd_done",       1, 0, 0, 8'h00, 16'h3000, 0, 0, 0, 1, 16'h3003, 16'h3000, 0, 0, 1, 1, 0);
        tbl[8]  = mk("rd_idle",       1, 0, 0, 8'h00, 16'h3000, 0, 0, 0, 1, 16'h3003, 16'h3000, 0, 0, 0, 0, 0);
        tbl[9]  = mk("wr_ld",         1, 1, 0, 8'h00, 16'hFFFF, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 0);
        tbl[10] = mk("wr_start",      1, 0, 0, 8'h00, 16'hFFFF, 1, 1, 2, 1, 16'hFFFF, 16'hFFFF, 1, 1, 1, 0, 0);
        tbl[11] = mk("wr_wrap",       1, 0, 0, 8'h00, 16'hFFFF, 0, 0, 0, 1, 16'h0000, 16'hFFFF, 1, 1, 1, 0, 0);
        tbl[12] = mk("wr_done",       1, 0, 0, 8'h00, 16'hFFFF, 0, 0, 0, 1, 16'h0001, 16'hFFFF, 0, 0, 1, 1, 0);
        tbl[13] = mk("wr_idle",       1, 0, 0, 8'h00, 16'hFFFF, 0, 0, 0, 0, 16'h0001, 16'hFFFF, 0, 0, 0, 0, 0);
        tbl[14] = mk("bl0_start",     1, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 16'h0001, 16'h0000, 1, 0, 1, 0, 0);
        tbl[15] = mk("acc_ignore_req",1, 1, 0, 8'h00, 16'h5555, 1, 1, 3, 1, 16'h0002, 16'h5555, 0, 0, 1, 1, 0);
        tbl[16] = mk("done_ign_start",1, 0, 0, 8'h00, 16'h0000, 1, 1, 2, 1, 16'h0002, 16'h0000, 0, 0, 0, 0, 0);
        tbl[17] = mk("still_idle",    1, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0002, 16'h0000, 0, 0, 0, 0, 0);
        tbl[18] = mk("ld_and_start",  1, 1, 1, 8'h80, 16'h0000, 1, 0, 1, 1, 16'h0080, 16'h0080, 1, 0, 1, 0, 0);
        tbl[19] = mk("ldst_done",     1, 0, 1, 8'h80, 16'h0000, 0, 0, 0, 1, 16'h0081, 16'h0080, 0, 0, 1, 1, 0);
        tbl[20] = mk("ldst_idle",     1, 0, 1, 8'h80, 16'h0000, 0, 0, 0, 0, 16'h0081, 16'h0080, 0, 0, 0, 0, 0);
        tbl[21] = mk("clamp_start",   1, 0, 0, 8'h00, 16'h0000, 1, 0, 7, 1, 16'h0081, 16'h0000, 1, 0, 1, 0, 0);
        tbl[22] = mk("clamp_w1",      1, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 1, 16'h0082, 16'h0000, 1, 0, 1, 0, 0);
        tbl[23] = mk("clamp_w2",      1, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 1, 16'h0083, 16'h0000, 1, 0, 1, 0, 0);
        tbl[24] = mk("clamp_w3",      1, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 1, 16'h0084, 16'h0000, 1, 0, 1, 0, 0);
        tbl[25] = mk("clamp_done",    1, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 1, 16'h0085, 16'h0000, 0, 0, 1, 1, 0);
        tbl[26] = mk("clamp_idle",    1, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0085, 16'h0000, 0, 0, 0, 0, 0);

        drive(0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].r, tbl[i].ld, tbl[i].sel, tbl[i].v, tbl[i].e,
                  tbl[i].st, tbl[i].w, tbl[i].bl, tbl[i].rdy);
            tick();
            chk({tbl[i].nm, " mar_q"},    32'(bus.mar_q),    32'(tbl[i].e_mar));
            chk({tbl[i].nm, " mem_addr"}, 32'(bus.mem_addr), 32'(tbl[i].e_mar));
            chk({tbl[i].nm, " mar_mux"},  32'(bus.mar_mux),  32'(tbl[i].e_mux));
            chk({tbl[i].nm, " mem_en"},   32'(bus.mem_en),   32'(tbl[i].e_en));
            chk({tbl[i].nm, " mem_we"},   32'(bus.mem_we),   32'(tbl[i].e_we));
            chk({tbl[i].nm, " busy"},     32'(bus.busy),     32'(tbl[i].e_busy));
            chk({tbl[i].nm, " done"},     32'(bus.done),     32'(tbl[i].e_done));
            chk({tbl[i].nm, " err"},      32'(bus.err),      32'(tbl[i].e_err));
        end

        // ---------------- timeout: mem_ready never arrives ----------------
        drive(1, 0, 0, 8'h00, 16'h0000, 1, 1, 2, 0);
        tick();
        chk("to_start mem_we", 32'(bus.mem_we), 32'd1);
        drive(1, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0);
        for (int i = 1; i <= WAIT_MAX + 1; i++) begin
            tick();
            chk($sformatf("to_stall%0d busy", i), 32'(bus.busy), 32'(i <= WAIT_MAX));
            chk($sformatf("to_stall%0d err", i),  32'(bus.err),  32'(i > WAIT_MAX));
            check_model($sformatf("to_stall%0d", i));
        end
        chk("to_abort mar_q", 32'(bus.mar_q), 32'h0085);
        // mem_ready in IDLE must not move the MAR nor clear err
        drive(1, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 1);
        tick();
        tick();
        chk("to_idle_rdy mar_q", 32'(bus.mar_q), 32'h0085);
        chk("to_idle_rdy err",   32'(bus.err),   32'd1);
        drive(1, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 1);
        tick();
        chk("to_restart err",  32'(bus.err),  32'd0);
        chk("to_restart busy", 32'(bus.busy), 32'd1);
        drive(1, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 1);
        tick();
        check_model("to_redo");
        tick();

        // ---------------- reset in the middle of a burst ----------------
        drive(1, 1, 0, 8'h00, 16'h4000, 1, 0, 4, 1);
        tick();
        drive(1, 0, 0, 8'h00, 16'h4000, 0, 0, 0, 1);
        tick();
        chk("mid_burst mar_q", 32'(bus.mar_q), 32'h4001);
        rst_n = 1'b0;
        tick();
        chk("mid_rst busy",  32'(bus.busy),  32'd0);
        chk("mid_rst mem_en",32'(bus.mem_en),32'd0);
        chk("mid_rst mar_q", 32'(bus.mar_q), 32'h0000);
        chk("mid_rst done",  32'(bus.done),  32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst done", 32'(bus.done), 32'd0);
        chk("post_rst err",  32'(bus.err),  32'd0);
        check_model("post_rst");

        // ---------------- randomized traffic against the model ----------------
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)),
                  8'($urandom),
                  ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom),
                  ($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < ((c / 500) % 2 == 1 ? 1 : 7)));
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
